// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM stage: default widths, FSM encoding,
// and the control slice of the MEM/WB bundle.
package mem_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;
  localparam int OPC_W      = 3;
  localparam int DEST_W     = 5;
  localparam int CNT_W      = 8;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic              reg_write;
    logic              mem_write;
    logic [DEST_W-1:0] dest;
  } ctl_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB output register bank; 1-cycle, no backpressure (captures every cycle).
// Write enables are gated by valid; payload only updates on valid beats.
module mem_wb_reg
  import mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              nxt_vld,
  input  ctl_t              nxt_ctl,
  input  logic [ADDR_W-1:0] nxt_imm,
  input  logic [DATA_W-1:0] nxt_acc,
  input  logic [DATA_W-1:0] nxt_reg,
  input  logic [DATA_W-1:0] nxt_mem,
  output logic              out_valid,
  output logic [OPC_W-1:0]  out_opcode,
  output logic              out_reg_write,
  output logic              out_mem_write,
  output logic [DEST_W-1:0] out_dest,
  output logic [ADDR_W-1:0] out_imm,
  output logic [DATA_W-1:0] out_acc_data,
  output logic [DATA_W-1:0] out_reg_data,
  output logic [DATA_W-1:0] out_mem_data
);

  logic              vld_q;
  ctl_t              ctl_q;
  logic [ADDR_W-1:0] imm_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] reg_q;
  logic [DATA_W-1:0] mem_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      ctl_q <= '0;
      imm_q <= '0;
      acc_q <= '0;
      reg_q <= '0;
      mem_q <= '0;
    end else begin
      vld_q <= nxt_vld;
      if (nxt_vld) begin
        ctl_q <= nxt_ctl;
        imm_q <= nxt_imm;
        acc_q <= nxt_acc;
        reg_q <= nxt_reg;
        mem_q <= nxt_mem;
      end
    end
  end

  assign out_valid     = vld_q;
  assign out_opcode    = ctl_q.opcode;
  assign out_reg_write = vld_q & ctl_q.reg_write;
  assign out_mem_write = vld_q & ctl_q.mem_write;
  assign out_dest      = ctl_q.dest;
  assign out_imm       = imm_q;
  assign out_acc_data  = acc_q;
  assign out_reg_data  = reg_q;
  assign out_mem_data  = mem_q;

endmodule

// File: rtl/mem_stage.sv
// MEM stage: non-loads 1 cycle, loads 2 + ack-wait cycles via dmem req/ack with timeout.
// Backpressure: stall_out holds upstream while a load is in REQ. MEM_STORE_FWD_EN adds a last-store buffer.
module mem_stage
  import mem_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [OPC_W-1:0]  in_opcode,
  input  logic              in_reg_write,
  input  logic              in_mem_write,
  input  logic              in_mem_read,
  input  logic [DEST_W-1:0] in_dest,
  input  logic [ADDR_W-1:0] in_imm,
  input  logic [DATA_W-1:0] in_acc_data,
  input  logic [DATA_W-1:0] in_reg_data,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic              flush,
  output logic              stall_out,
  output logic              dmem_req,
  output logic [ADDR_W-1:0] dmem_addr,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              out_valid,
  output logic [OPC_W-1:0]  out_opcode,
  output logic              out_reg_write,
  output logic              out_mem_write,
  output logic [DEST_W-1:0] out_dest,
  output logic [ADDR_W-1:0] out_imm,
  output logic [DATA_W-1:0] out_acc_data,
  output logic [DATA_W-1:0] out_reg_data,
  output logic [DATA_W-1:0] out_mem_data,
  output logic              err_timeout
);

  state_t            state;
  logic [CNT_W-1:0]  to_cnt;
  ctl_t              in_ctl;
  ctl_t              lat_ctl;
  logic [DATA_W-1:0] lat_acc;
  logic [DATA_W-1:0] lat_mem;
  logic              accept;
  logic              is_load;
  logic              timeout_hit;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  logic              wb_vld;
  ctl_t              wb_ctl;
  logic [ADDR_W-1:0] wb_imm;
  logic [DATA_W-1:0] wb_acc;
  logic [DATA_W-1:0] wb_reg;
  logic [DATA_W-1:0] wb_mem;

  assign in_ctl      = {in_opcode, in_reg_write, in_mem_write, in_dest};
  assign accept      = (state == IDLE) & in_valid & ~flush;
  // A read+write combination is a store; only a pure read is a load.
  assign is_load     = in_mem_read & ~in_mem_write;
  assign timeout_hit = (state == REQ) & ~dmem_ack & (to_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign stall_out   = (state == REQ);

`ifdef MEM_STORE_FWD_EN
  logic              buf_vld;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;

  // Survives flush on purpose: only accepted stores update it, only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_vld  <= 1'b0;
      buf_addr <= '0;
      buf_data <= '0;
    end else if (accept & in_mem_write) begin
      buf_vld  <= 1'b1;
      buf_addr <= in_imm;
      buf_data <= in_store_data;
    end
  end

  assign fwd_hit  = accept & is_load & buf_vld & (in_imm == buf_addr);
  assign fwd_data = buf_data;
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  always_comb begin
    wb_vld = 1'b0;
    wb_ctl = in_ctl;
    wb_imm = in_imm;
    wb_acc = in_acc_data;
    wb_reg = in_reg_data;
    wb_mem = in_store_data;
    if (state == REQ) begin
      wb_ctl = lat_ctl;
      wb_imm = dmem_addr;
      wb_acc = lat_acc;
      wb_mem = lat_mem;
      wb_reg = dmem_ack ? dmem_rdata : '0;
      wb_vld = dmem_ack | timeout_hit;
    end else if (accept) begin
      wb_vld = ~is_load | fwd_hit;
      if (fwd_hit) wb_reg = fwd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      to_cnt      <= '0;
      dmem_req    <= 1'b0;
      dmem_addr   <= '0;
      err_timeout <= 1'b0;
      lat_ctl     <= '0;
      lat_acc     <= '0;
      lat_mem     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept & is_load & ~fwd_hit) begin
            state     <= REQ;
            dmem_req  <= 1'b1;
            dmem_addr <= in_imm;
            to_cnt    <= '0;
            lat_ctl   <= in_ctl;
            lat_acc   <= in_acc_data;
            lat_mem   <= in_store_data;
          end
        end
        REQ: begin
          // Ack takes priority over a coincident timeout.
          if (dmem_ack) begin
            state    <= IDLE;
            dmem_req <= 1'b0;
            to_cnt   <= '0;
          end else if (timeout_hit) begin
            state       <= IDLE;
            dmem_req    <= 1'b0;
            to_cnt      <= '0;
            err_timeout <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mem_wb_reg #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem_wb_reg (
    .clk           (clk),
    .rst           (rst),
    .nxt_vld       (wb_vld),
    .nxt_ctl       (wb_ctl),
    .nxt_imm       (wb_imm),
    .nxt_acc       (wb_acc),
    .nxt_reg       (wb_reg),
    .nxt_mem       (wb_mem),
    .out_valid     (out_valid),
    .out_opcode    (out_opcode),
    .out_reg_write (out_reg_write),
    .out_mem_write (out_mem_write),
    .out_dest      (out_dest),
    .out_imm       (out_imm),
    .out_acc_data  (out_acc_data),
    .out_reg_data  (out_reg_data),
    .out_mem_data  (out_mem_data)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage; inputs change 1 time unit after posedge, outputs checked there.
module tb_mem_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_reg_write, in_mem_write, in_mem_read, flush;
  logic [2:0] in_opcode;
  logic [4:0] in_dest;
  logic [7:0] in_imm, in_acc_data, in_reg_data, in_store_data;
  logic       stall_out, dmem_req, dmem_ack;
  logic [7:0] dmem_addr, dmem_rdata;
  logic       out_valid, out_reg_write, out_mem_write, err_timeout;
  logic [2:0] out_opcode;
  logic [4:0] out_dest;
  logic [7:0] out_imm, out_acc_data, out_reg_data, out_mem_data;

  int vecs = 0;
  int errs = 0;
  int stall_cnt;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_opcode(in_opcode), .in_reg_write(in_reg_write),
    .in_mem_write(in_mem_write), .in_mem_read(in_mem_read), .in_dest(in_dest),
    .in_imm(in_imm), .in_acc_data(in_acc_data), .in_reg_data(in_reg_data),
    .in_store_data(in_store_data), .flush(flush), .stall_out(stall_out),
    .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .out_valid(out_valid), .out_opcode(out_opcode), .out_reg_write(out_reg_write),
    .out_mem_write(out_mem_write), .out_dest(out_dest), .out_imm(out_imm),
    .out_acc_data(out_acc_data), .out_reg_data(out_reg_data), .out_mem_data(out_mem_data),
    .err_timeout(err_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_opcode = 0; in_reg_write = 0; in_mem_write = 0; in_mem_read = 0;
    in_dest = 0; in_imm = 0; in_acc_data = 0; in_reg_data = 0; in_store_data = 0;
    flush = 0; dmem_ack = 0; dmem_rdata = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    step(); step();
    rst = 0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_stall", stall_out, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_dmem_addr", dmem_addr, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_reg_data", out_reg_data, 0);

    // ALU op passes in one cycle
    in_valid = 1; in_opcode = 3'd1; in_reg_write = 1; in_dest = 5'd5;
    in_acc_data = 8'h3C; in_reg_data = 8'h11; in_store_data = 8'h99; in_imm = 8'h12;
    #1 chk("alu_stall_pre", stall_out, 0);
    step();
    chk("alu_valid", out_valid, 1);
    chk("alu_acc", out_acc_data, 8'h3C);
    chk("alu_dest", out_dest, 5);
    chk("alu_regwr", out_reg_write, 1);
    chk("alu_memwr", out_mem_write, 0);
    chk("alu_reg_data", out_reg_data, 8'h11);
    chk("alu_mem_data", out_mem_data, 8'h99);
    chk("alu_opcode", out_opcode, 1);
    chk("alu_stall", stall_out, 0);
    idle_inputs();
    step();
    chk("bubble_valid", out_valid, 0);
    chk("bubble_regwr_gated", out_reg_write, 0);

    // Load, ack after 3 waiting cycles
    in_valid = 1; in_mem_read = 1; in_reg_write = 1; in_dest = 5'd7; in_imm = 8'h20; in_opcode = 3'd4;
    stall_cnt = 0;
    step();
    chk("ld_req", dmem_req, 1);
    chk("ld_addr", dmem_addr, 8'h20);
    chk("ld_valid_bubble", out_valid, 0);
    if (stall_out) stall_cnt++;
    step(); if (stall_out) stall_cnt++;
    step(); if (stall_out) stall_cnt++;
    chk("ld_addr_stable", dmem_addr, 8'h20);
    dmem_ack = 1; dmem_rdata = 8'hA5;
    step();
    if (stall_out) stall_cnt++;
    chk("ld_stall_cycles", stall_cnt, 3);
    chk("ld_valid", out_valid, 1);
    chk("ld_rdata", out_reg_data, 8'hA5);
    chk("ld_dest", out_dest, 7);
    chk("ld_req_drop", dmem_req, 0);
    chk("ld_no_err", err_timeout, 0);
    idle_inputs();
    step();
    chk("ld_valid_once", out_valid, 0);

    // Load with no ack times out after 15 REQ cycles
    in_valid = 1; in_mem_read = 1; in_reg_write = 1; in_dest = 5'd3; in_imm = 8'h30;
    stall_cnt = 0;
    step();
    if (stall_out) stall_cnt++;
    for (int i = 0; i < 14; i++) begin
      step();
      if (stall_out) stall_cnt++;
    end
    chk("to_no_err_yet", err_timeout, 0);
    step();
    chk("to_stall_cycles", stall_cnt, 15);
    chk("to_valid", out_valid, 1);
    chk("to_reg_data", out_reg_data, 0);
    chk("to_err", err_timeout, 1);
    chk("to_idle", stall_out, 0);
    idle_inputs();
    in_valid = 1; in_reg_write = 1; in_dest = 5'd9; in_acc_data = 8'h55;
    step();
    chk("post_to_alu_valid", out_valid, 1);
    chk("post_to_alu_acc", out_acc_data, 8'h55);
    chk("err_sticky", err_timeout, 1);

    // Flushed store is discarded
    idle_inputs();
    in_valid = 1; in_mem_write = 1; in_store_data = 8'h66; in_imm = 8'h50; flush = 1;
    step();
    chk("flush_valid", out_valid, 0);
    chk("flush_memwr", out_mem_write, 0);

    // Flush while a load is in REQ does not kill it
    idle_inputs();
    in_valid = 1; in_mem_read = 1; in_reg_write = 1; in_dest = 5'd4; in_imm = 8'h21;
    step();
    flush = 1;
    step(); step();
    chk("flush_req_stall", stall_out, 1);
    dmem_ack = 1; dmem_rdata = 8'h3A;
    step();
    chk("flush_req_valid", out_valid, 1);
    chk("flush_req_rdata", out_reg_data, 8'h3A);
    chk("flush_req_dest", out_dest, 4);

    // Ack in IDLE is ignored
    idle_inputs();
    dmem_ack = 1; dmem_rdata = 8'hEE;
    step();
    chk("idle_ack_valid", out_valid, 0);
    chk("idle_ack_stall", stall_out, 0);

    // Read+write together behaves as a store
    idle_inputs();
    in_valid = 1; in_mem_read = 1; in_mem_write = 1; in_store_data = 8'h5A; in_imm = 8'h70;
    step();
    chk("rw_valid", out_valid, 1);
    chk("rw_memwr", out_mem_write, 1);
    chk("rw_stall", stall_out, 0);
    chk("rw_req", dmem_req, 0);

    // Store 0x77 to 0x40 then load 0x40
    idle_inputs();
    in_valid = 1; in_mem_write = 1; in_store_data = 8'h77; in_imm = 8'h40;
    step();
    chk("st_valid", out_valid, 1);
    chk("st_memwr", out_mem_write, 1);
    chk("st_mem_data", out_mem_data, 8'h77);
    idle_inputs();
    in_valid = 1; in_mem_read = 1; in_reg_write = 1; in_dest = 5'd2; in_imm = 8'h40;
    step();
`ifdef MEM_STORE_FWD_EN
    chk("fwd_valid", out_valid, 1);
    chk("fwd_data", out_reg_data, 8'h77);
    chk("fwd_no_req", dmem_req, 0);
    chk("fwd_no_stall", stall_out, 0);
    idle_inputs();
    step();
`else
    chk("nofwd_req", dmem_req, 1);
    chk("nofwd_stall", stall_out, 1);
    chk("nofwd_addr", dmem_addr, 8'h40);
    dmem_ack = 1; dmem_rdata = 8'h12;
    step();
    chk("nofwd_valid", out_valid, 1);
    chk("nofwd_data", out_reg_data, 8'h12);
    idle_inputs();
    step();
`endif

    // Reset while in REQ abandons the load and clears the sticky error
    in_valid = 1; in_mem_read = 1; in_reg_write = 1; in_dest = 5'd6; in_imm = 8'h60;
    step();
    step();
    chk("rq_stall", stall_out, 1);
    chk("rq_err_before", err_timeout, 1);
    rst = 1;
    step();
    chk("rq_rst_req", dmem_req, 0);
    chk("rq_rst_stall", stall_out, 0);
    chk("rq_rst_valid", out_valid, 0);
    chk("rq_rst_err", err_timeout, 0);
    chk("rq_rst_addr", dmem_addr, 0);
    chk("rq_rst_acc", out_acc_data, 0);
    chk("rq_rst_dest", out_dest, 0);
    rst = 0;
    idle_inputs();
    step();
    chk("post_rst_idle", stall_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
